bit_unstuff_block: RTL and testbench
====================================

BIT_UNSTUFF_BLOCK -- requirements
Module: bit_unstuff_block

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default 6, the count of consecutive ones after which a stuffed zero is expected.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port enable_data, input, 1, data_in valid this cycle.
REQ-005 The block SHALL have port data_in, input, 1, NRZI-decoded serial bit, LSB of each byte first.
REQ-006 The block SHALL have port sync_clr, input, 1, synchronous packet-boundary clear.
REQ-007 The block SHALL have port data_out, output, 1, destuffed bit.
REQ-008 The block SHALL have port bit_valid, output, 1, one-cycle pulse qualifying data_out.
REQ-009 The block SHALL have port stuff_drop, output, 1, one-cycle pulse when a stuffed zero is removed.
REQ-010 The block SHALL have port byte_out, output, 8, last assembled byte, LSB first.
REQ-011 The block SHALL have port byte_valid, output, 1, one-cycle pulse qualifying byte_out.
REQ-012 The block SHALL have port stuff_err, output, 1, sticky stuffing violation flag.

Function
REQ-013 The block SHALL implement a state machine with states RUN, CHK and ERR.
REQ-014 RUN: each accepted bit (enable_data=1) SHALL be forwarded (data_out<=data_in, bit_valid=1 on the next cycle); the ones counter increments on 1 and clears on 0.
REQ-015 When the ones counter reaches RUN_LEN, the block SHALL clear the counter and enter CHK.
REQ-016 CHK: an accepted 0 SHALL NOT be forwarded; bit_valid stays 0, stuff_drop pulses once, and the state returns to RUN.
REQ-017 CHK: an accepted 1 SHALL be handled per REQ-030/REQ-031.
REQ-018 With enable_data=0, state, counters and the shift register SHALL hold, and all pulse outputs SHALL be 0.
REQ-019 Every forwarded bit SHALL be written to shift[idx] (idx 0..7); stuffed bits SHALL never advance idx.
REQ-020 On the forwarded bit with idx=7, the block SHALL load byte_out, pulse byte_valid in the same cycle as that bit's bit_valid, and wrap idx to 0.
REQ-021 Latency SHALL be exactly 1 cycle from an accepted bit to its bit_valid or stuff_drop pulse.
REQ-022 The ones counter SHALL NOT clear at byte boundaries, so runs spanning bytes are detected.
REQ-023 ERR: accepted bits SHALL be ignored, with no bit_valid, byte_valid or stuff_drop pulses; exit is only via sync_clr or rst.
REQ-024 When sync_clr=1, the next state SHALL be RUN, with ones counter 0, idx 0, partial byte discarded, stuff_err 0 and all pulses 0.
REQ-025 sync_clr SHALL take priority over a same-cycle enable_data, and that bit SHALL be discarded.
REQ-026 byte_out SHALL hold its value until the next completed byte and SHALL NOT be cleared by sync_clr.

Reset
REQ-027 When rst=0, the block SHALL clear immediately, without waiting for clk: data_out, bit_valid, stuff_drop, byte_valid and stuff_err to 0, byte_out to 8'h00, state to RUN, counters and idx to 0.
REQ-028 A reset mid-packet SHALL discard the partial byte; no pulse SHALL be emitted after deassertion until a bit is accepted.
REQ-029 The block SHALL have no other reset source except sync_clr.

Configuration
REQ-030 With STUFF_ERR_EN defined, a 1 accepted in CHK SHALL move the block to ERR and set stuff_err=1 on the next cycle, held until sync_clr or rst.
REQ-031 With STUFF_ERR_EN undefined, there SHALL be no ERR state and stuff_err SHALL be tied 0; a 1 accepted in CHK is forwarded as data, the ones counter is set to 1, and the state returns to RUN.

Verification
REQ-032 Stream 8'hA5 (1,0,1,0,0,1,0,1) contiguous -> 8 bit_valid pulses, byte_valid with byte_out=8'hA5, stuff_drop never asserted.
REQ-033 Stream 1,1,1,1,1,1,0,1,1 -> stuff_drop one pulse, 1 cycle after the 7th input; 8 bit_valid pulses; byte_out=8'hFF.
REQ-034 With STUFF_ERR_EN, seven consecutive 1s -> stuff_err=1 one cycle after the 7th bit, 6 bit_valid pulses total, no further pulses; then sync_clr -> stuff_err=0, and the next byte 8'h12 decodes correctly.
REQ-035 Without STUFF_ERR_EN, seven consecutive 1s -> stuff_err stays 0, 7 bit_valid pulses.
REQ-036 8'h3C with enable_data alternating 1/0 -> exactly one byte_valid, byte_out=8'h3C, no pulse in idle cycles.
REQ-037 5 bits sent, then rst low for 2 cycles (or sync_clr with a same-cycle bit), then 8'h0F -> byte_out=8'h0F, with no stale bits merged.

Source files
------------

// File: rtl/bit_unstuff_block.sv
// bit_unstuff_block: serial bit de-stuffer with LSB-first byte assembly.
// After RUN_LEN consecutive ones the next bit is expected to be a stuffed
// zero, which is removed. Optional feature macro: STUFF_ERR_EN. When it is
// defined, a one in that slot is a stuffing violation: the block locks into
// ERR and raises the sticky stuff_err flag. When it is undefined, the one is
// kept as data and starts a new run.
module bit_unstuff_block #(
    parameter int RUN_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_data,
    input  logic       data_in,
    input  logic       sync_clr,
    output logic       data_out,
    output logic       bit_valid,
    output logic       stuff_drop,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stuff_err
);

    localparam int CW = $clog2(RUN_LEN + 1);

`ifdef STUFF_ERR_EN
    typedef enum logic [1:0] {RUN = 2'd0, CHK = 2'd1, ERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, CHK = 2'd1} state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_ones;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_data_out;
    logic            r_bit_valid;
    logic            r_stuff_drop;
    logic [7:0]      r_byte_out;
    logic            r_byte_valid;

    state_t          w_nstate;
    logic [CW-1:0]   w_nones;
    logic            w_fwd;
    logic            w_drop;
    logic            w_err;
    logic [7:0]      w_byte;

    // Next-state decision for one accepted bit: forward, drop or flag error
    always_comb begin
        w_nstate = r_state;
        w_nones  = r_ones;
        w_fwd    = 1'b0;
        w_drop   = 1'b0;
        w_err    = 1'b0;
        if (enable_data) begin
            case (r_state)
                RUN: begin
                    w_fwd = 1'b1;
                    if (data_in) begin
                        if (r_ones == CW'(RUN_LEN - 1)) begin
                            w_nones  = '0;
                            w_nstate = CHK;
                        end else begin
                            w_nones = r_ones + CW'(1);
                        end
                    end else begin
                        w_nones = '0;
                    end
                end
                CHK: begin
                    if (!data_in) begin
                        w_drop   = 1'b1;
                        w_nstate = RUN;
                    end else begin
`ifdef STUFF_ERR_EN
                        w_err    = 1'b1;
                        w_nstate = ERR;
`else
                        // The one is data and already counts as the first of a new run
                        w_fwd = 1'b1;
                        if (RUN_LEN == 1) begin
                            w_nones  = '0;
                            w_nstate = CHK;
                        end else begin
                            w_nones  = CW'(1);
                            w_nstate = RUN;
                        end
`endif
                    end
                end
                default: begin
                    // ERR ignores data until sync_clr or rst
                    w_nstate = r_state;
                end
            endcase
        end
    end

    // Partial byte with the incoming bit merged at the current index
    always_comb begin
        w_byte        = r_shift;
        w_byte[r_idx] = data_in;
    end

    // State, counters, byte assembly and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_ones       <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data_out   <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_bit_valid  <= 1'b0;
            r_stuff_drop <= 1'b0;
            r_byte_valid <= 1'b0;
            if (sync_clr) begin
                r_state <= RUN;
                r_ones  <= '0;
                r_idx   <= '0;
                r_shift <= '0;
            end else begin
                r_state      <= w_nstate;
                r_ones       <= w_nones;
                r_stuff_drop <= w_drop;
                if (w_fwd) begin
                    r_bit_valid <= 1'b1;
                    r_data_out  <= data_in;
                    r_shift     <= w_byte;
                    if (r_idx == 3'd7) begin
                        r_byte_out   <= w_byte;
                        r_byte_valid <= 1'b1;
                        r_idx        <= '0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
            end
        end
    end

`ifdef STUFF_ERR_EN
    logic r_stuff_err;

    // Sticky violation flag, cleared only by sync_clr or rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_stuff_err <= 1'b0;
        else if (sync_clr) r_stuff_err <= 1'b0;
        else if (w_err)    r_stuff_err <= 1'b1;
    end

    assign stuff_err = r_stuff_err;
`else
    assign stuff_err = 1'b0;
`endif

    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign stuff_drop = r_stuff_drop;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;

endmodule

// File: tb/tb_bit_unstuff_block.sv
// Scoreboard bench for bit_unstuff_block: directed streams plus random traffic.
module tb_bit_unstuff_block;

    localparam int RUN_LEN = 6;
`ifdef STUFF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       enable_data;
    logic       data_in;
    logic       sync_clr;
    logic       data_out;
    logic       bit_valid;
    logic       stuff_drop;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       stuff_err;

    bit_unstuff_block #(.RUN_LEN(RUN_LEN)) dut (
        .clk(clk), .rst(rst), .enable_data(enable_data), .data_in(data_in),
        .sync_clr(sync_clr), .data_out(data_out), .bit_valid(bit_valid),
        .stuff_drop(stuff_drop), .byte_out(byte_out), .byte_valid(byte_valid),
        .stuff_err(stuff_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         drop;
        bit         d;
        bit         bv;
        logic [7:0] b;
        int         stamp;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ecount = 0;

    // Reference model state: run length so far, waiting-for-stuff flag,
    // error lock, bits of the byte being assembled, last completed byte.
    int         m_ones = 0;
    bit         m_chk  = 0;
    bit         m_err  = 0;
    bit         m_part[$];
    logic [7:0] m_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, ecount);
    endtask

    task automatic m_clear();
        m_ones = 0;
        m_chk  = 0;
        m_err  = 0;
        m_part.delete();
    endtask

    task automatic m_forward(input bit d);
        exp_t e;
        logic [7:0] b;
        m_part.push_back(d);
        e.drop  = 0;
        e.d     = d;
        e.stamp = ecount;
        e.bv    = 0;
        e.b     = 8'h00;
        if (m_part.size() == 8) begin
            for (int i = 0; i < 8; i++) b[i] = m_part[i];
            m_byte = b;
            e.bv   = 1;
            e.b    = b;
            m_part.delete();
        end
        q.push_back(e);
    endtask

    task automatic m_accept(input bit d);
        exp_t e;
        if (m_err) return;
        if (m_chk) begin
            m_chk = 0;
            if (!d) begin
                e.drop = 1; e.d = 0; e.bv = 0; e.b = 8'h00; e.stamp = ecount;
                q.push_back(e);
            end else if (ERR_EN) begin
                m_err = 1;
            end else begin
                m_forward(1'b1);
                m_ones = 1;
                if (m_ones >= RUN_LEN) begin m_ones = 0; m_chk = 1; end
            end
        end else begin
            m_forward(d);
            m_ones = d ? m_ones + 1 : 0;
            if (m_ones >= RUN_LEN) begin m_ones = 0; m_chk = 1; end
        end
    endtask

    // One clock of stimulus; model sees the same edge the DUT samples
    task automatic send(input bit en, input bit d, input bit clr);
        enable_data = en;
        data_in     = d;
        sync_clr    = clr;
        @(posedge clk);
        ecount++;
        if (clr)     m_clear();
        else if (en) m_accept(d);
        #1;
        enable_data = 1'b0;
        sync_clr    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit alt);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, b[i], 1'b0);
            if (alt) send(1'b0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        m_clear();
        m_byte = 8'h00;
        #1;
        check("async_reset_outputs",
              {data_out, bit_valid, stuff_drop, byte_valid, stuff_err, byte_out}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Monitor: pops expected pulses and checks held outputs every cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bit_valid || stuff_drop || byte_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {bit_valid, stuff_drop, byte_valid}, 32'h0);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", ecount, e.stamp);
                    check("stuff_drop", stuff_drop, e.drop);
                    check("bit_valid", bit_valid, !e.drop);
                    if (!e.drop) check("data_out", data_out, e.d);
                    check("byte_valid", byte_valid, e.bv);
                    if (e.bv) check("byte_out", byte_out, e.b);
                end
            end else if (q.size() != 0 && q[0].stamp <= ecount) begin
                check("missing_pulse", ecount + 1, q[0].stamp);
                void'(q.pop_front());
            end
            check("stuff_err", stuff_err, m_err);
            check("byte_out_hold", byte_out, m_byte);
        end
    end

    initial begin
        logic [8:0] seq33;
        rst         = 1'b0;
        enable_data = 1'b0;
        data_in     = 1'b0;
        sync_clr    = 1'b0;
        #1;
        check("reset_state",
              {data_out, bit_valid, stuff_drop, byte_valid, stuff_err, byte_out}, 32'h0);
        #20;
        @(negedge clk);
        #2 rst = 1'b1;
        idle(2);

        // Plain byte, no stuffing
        send_byte(8'hA5, 1'b0);
        idle(3);

        // Six ones, stuffed zero, two ones
        seq33 = 9'b1_1011_1111;
        for (int i = 0; i < 9; i++) send(1'b1, seq33[i], 1'b0);
        idle(3);

        // Seven ones, then clear and a clean byte
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1'b0);
        idle(3);
        check("seven_ones_err", stuff_err, ERR_EN);
        send(1'b0, 1'b0, 1'b1);
        send_byte(8'h12, 1'b0);
        idle(3);

        // Gapped enable
        send(1'b0, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(3);

        // Partial byte dropped by async reset
        for (int i = 0; i < 5; i++) send(1'b1, 1'($urandom), 1'b0);
        do_reset();
        send_byte(8'h0F, 1'b0);
        idle(3);

        // Partial byte dropped by sync_clr with a same-cycle bit
        for (int i = 0; i < 5; i++) send(1'b1, 1'($urandom), 1'b0);
        send(1'b1, 1'b1, 1'b1);
        send_byte(8'h0F, 1'b0);
        idle(3);

        // Random traffic biased toward ones to exercise runs and stuffing
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            send(r < 80, $urandom_range(0, 9) < 7, r >= 98);
        end
        idle(5);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
